// File: rtl/ahb3lite_mem_slave.sv
// AHB3-Lite memory slave: word storage with byte-lane writes, fixed wait states
// and a two-cycle ERROR response for illegal transfers.
module ahb3lite_mem_slave #(
   parameter int XLEN           = 32,
   parameter int PHYS_ADDR_SIZE = XLEN,
   parameter int MEM_SIZE       = 4096,
   parameter int WAIT_STATES    = 0
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      HSEL,
   input  logic [PHYS_ADDR_SIZE-1:0] HADDR,
   input  logic [XLEN-1:0]           HWDATA,
   output logic [XLEN-1:0]           HRDATA,
   input  logic                      HWRITE,
   input  logic [2:0]                HSIZE,
   input  logic [2:0]                HBURST,
   input  logic [3:0]                HPROT,
   input  logic [1:0]                HTRANS,
   input  logic                      HMASTLOCK,
   input  logic                      HREADY,
   output logic                      HREADYOUT,
   output logic                      HRESP
);

   localparam int BYTES  = XLEN / 8;
   localparam int LANE_W = $clog2(BYTES);
   localparam int MEM_AW = $clog2(MEM_SIZE);
   localparam int IDX_W  = MEM_AW - LANE_W;
   localparam int WORDS  = MEM_SIZE / BYTES;
   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   function automatic logic [BYTES-1:0] lane_mask(input logic [2:0] size,
                                                  input logic [LANE_W-1:0] off);
      int nbytes;
      nbytes    = 1 << size;
      lane_mask = '0;
      for (int i = 0; i < BYTES; i++) begin
         lane_mask[i] = (i >= int'(off)) && (i < int'(off) + nbytes);
      end
   endfunction

   function automatic logic xfer_error(input logic [PHYS_ADDR_SIZE-1:0] addr,
                                       input logic [2:0] size);
      logic [63:0] a;
      logic [63:0] nbytes;
      a          = 64'(addr);
      nbytes     = 64'd1 << size;
      xfer_error = (a >= 64'(MEM_SIZE)) ||
                   ((a & (nbytes - 64'd1)) != 64'd0) ||
                   (nbytes > 64'(BYTES));
   endfunction

   function automatic logic [XLEN-1:0] expand(input logic [BYTES-1:0] m);
      expand = '0;
      for (int i = 0; i < BYTES; i++) begin
         expand[8*i +: 8] = {8{m[i]}};
      end
   endfunction

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               write_q, write_d;
   logic [XLEN-1:0]    hrdata_q, hrdata_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [BYTES-1:0]   mask_q, mask_d;
   logic [XLEN-1:0]    mem_q [WORDS];

   logic               open_st;
   logic               accept;
   logic               req_err;
   logic               commit;
   logic [IDX_W-1:0]   haddr_idx;
   logic [IDX_W-1:0]   rd_idx;
   logic [XLEN-1:0]    wmask;
   logic [XLEN-1:0]    rd_word;
   logic               unused_ok;

   assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

   // A new address phase is only sampled in states whose cycle closes the bus.
   assign open_st   = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
   assign accept    = open_st && HSEL && HREADY && HTRANS[1];
   assign req_err   = xfer_error(HADDR, HSIZE);
   assign commit    = (state_q == S_DATA) && write_q;
   assign haddr_idx = HADDR[MEM_AW-1:LANE_W];
   assign rd_idx    = (state_q == S_WAIT) ? idx_q : haddr_idx;
   assign wmask     = expand(mask_q);

   // Merge the write committing on this edge so a back-to-back read sees it.
   assign rd_word   = (commit && (idx_q == rd_idx)) ?
                      ((mem_q[rd_idx] & ~wmask) | (HWDATA & wmask)) : mem_q[rd_idx];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      write_d   = write_q;
      idx_d     = idx_q;
      mask_d    = mask_q;
      hrdata_d  = hrdata_q;
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;

      case (state_q)
         S_WAIT: begin
            HREADYOUT = 1'b0;
            if (cnt_q == 4'd0) begin
               state_d = S_DATA;
               if (!write_q) hrdata_d = rd_word;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
            state_d   = S_ERR2;
         end
         S_ERR2: begin
            HRESP = 1'b1;
         end
         default: ;
      endcase

      if (accept) begin
         idx_d   = haddr_idx;
         mask_d  = lane_mask(HSIZE, HADDR[LANE_W-1:0]);
         write_d = HWRITE;
         if (req_err) begin
            state_d = S_ERR1;
         end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
         end else begin
            state_d = S_DATA;
            if (!HWRITE) hrdata_d = rd_word;
         end
      end else if (open_st) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         write_q  <= 1'b0;
         hrdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         write_q  <= write_d;
         hrdata_q <= hrdata_d;
      end
   end

   always_ff @(posedge HCLK) begin
      idx_q  <= idx_d;
      mask_q <= mask_d;
   end

   // Reset forces IDLE asynchronously, so a write caught in WAIT never commits.
   always_ff @(posedge HCLK) begin
      if (commit) begin
         for (int i = 0; i < BYTES; i++) begin
            if (mask_q[i]) mem_q[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
         end
      end
   end

   assign HRDATA = hrdata_q;

endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
// Directed bench: one zero-wait and one three-wait-state slave on a shared bus.
module tb_ahb3lite_mem_slave;

   logic        HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   logic        HRESETn;
   logic        hsel, dsel, stall;
   logic [31:0] haddr, hwdata;
   logic        hwrite;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic        hmastlock;

   logic [31:0] rdata0, rdata1;
   logic        rdy0, rdy1, resp0, resp1;
   logic        sel0, sel1, hready;
   logic [31:0] rdata_mux;
   logic        resp_mux;

   assign sel0      = hsel & ~dsel;
   assign sel1      = hsel & dsel;
   assign hready    = rdy0 & rdy1 & ~stall;
   assign rdata_mux = dsel ? rdata1 : rdata0;
   assign resp_mux  = dsel ? resp1 : resp0;

   ahb3lite_mem_slave #(.XLEN(32), .PHYS_ADDR_SIZE(32), .MEM_SIZE(4096), .WAIT_STATES(0)) u_ws0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(haddr), .HWDATA(hwdata),
      .HRDATA(rdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready), .HREADYOUT(rdy0), .HRESP(resp0)
   );

   ahb3lite_mem_slave #(.XLEN(32), .PHYS_ADDR_SIZE(32), .MEM_SIZE(4096), .WAIT_STATES(3)) u_ws3 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel1), .HADDR(haddr), .HWDATA(hwdata),
      .HRDATA(rdata1), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready), .HREADYOUT(rdy1), .HRESP(resp1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Single non-pipelined transfer; reports read data, first/last HRESP and stall count.
   task automatic xfer(input logic d, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd, output logic r1,
                       output logic rl, output int nw);
      logic done;
      dsel   = d;
      hsel   = 1'b1;
      htrans = 2'b10;
      haddr  = a;
      hwrite = wr;
      hsize  = sz;
      @(posedge HCLK); #1;
      htrans = 2'b00;
      hsel   = 1'b0;
      hwdata = wd;
      nw = 0; r1 = 1'b0; rl = 1'b0; rd = '0; done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge HCLK);
         if (i == 0) r1 = resp_mux;
         if (hready) begin
            rd   = rdata_mux;
            rl   = resp_mux;
            done = 1'b1;
            break;
         end
         nw++;
      end
      @(posedge HCLK); #1;
      if (!done) check("xfer_timeout", {31'd0, done}, 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        r1, rl, r;
      int          nw, dp, cur;

      HRESETn = 1'b0; hsel = 1'b0; dsel = 1'b0; stall = 1'b0;
      haddr = '0; hwdata = '0; hwrite = 1'b0; hsize = 3'd2; htrans = 2'b00;
      hburst = 3'd0; hprot = 4'b0011; hmastlock = 1'b0;
      repeat (2) @(posedge HCLK);
      #1;
      check("rst_rdy", {rdy1, rdy0}, 32'h3);
      check("rst_resp", {resp1, resp0}, 32'h0);
      check("rst_rdata0", rdata0, 32'h0);
      check("rst_rdata1", rdata1, 32'h0);
      HRESETn = 1'b1;
      @(posedge HCLK); #1;

      // Back-to-back write then read of the same word, zero wait states
      dsel = 1'b0; hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
      @(posedge HCLK); #1;
      hwrite = 1'b0; hwdata = 32'hDEADBEEF;
      @(negedge HCLK);
      check("b2b_wr_rdy", rdy0, 32'h1);
      @(posedge HCLK); #1;
      htrans = 2'b00; hsel = 1'b0;
      @(negedge HCLK);
      check("b2b_rd_rdy", rdy0, 32'h1);
      check("b2b_fwd_data", rdata0, 32'hDEADBEEF);
      @(posedge HCLK); #1;

      // Byte lanes
      xfer(1'b0, 32'h20, 1'b1, 3'd2, 32'h11223344, rd, r1, rl, nw);
      xfer(1'b0, 32'h22, 1'b1, 3'd0, 32'h55AA5555, rd, r1, rl, nw);
      xfer(1'b0, 32'h20, 1'b0, 3'd2, 32'h0, rd, r1, rl, nw);
      check("lane_byte", rd, 32'h11AA3344);
      check("lane_byte_wait", nw, 32'd0);
      xfer(1'b0, 32'h20, 1'b1, 3'd1, 32'h7777BBCC, rd, r1, rl, nw);
      xfer(1'b0, 32'h20, 1'b0, 3'd2, 32'h0, rd, r1, rl, nw);
      check("lane_half", rd, 32'h11AABBCC);

      // Error responses
      xfer(1'b0, 32'h0, 1'b1, 3'd2, 32'h01234567, rd, r1, rl, nw);
      xfer(1'b0, 32'h1000, 1'b1, 3'd2, 32'hFFFFFFFF, rd, r1, rl, nw);
      check("err_oob_resp", {r1, rl}, 32'h3);
      check("err_oob_wait", nw, 32'd1);
      xfer(1'b0, 32'h0, 1'b0, 3'd2, 32'h0, rd, r1, rl, nw);
      check("err_oob_mem", rd, 32'h01234567);
      xfer(1'b0, 32'h21, 1'b1, 3'd1, 32'hFFFFFFFF, rd, r1, rl, nw);
      check("err_align_resp", {r1, rl}, 32'h3);
      check("err_align_wait", nw, 32'd1);
      xfer(1'b0, 32'h20, 1'b0, 3'd2, 32'h0, rd, r1, rl, nw);
      check("err_align_mem", rd, 32'h11AABBCC);
      xfer(1'b0, 32'h20, 1'b1, 3'd3, 32'hFFFFFFFF, rd, r1, rl, nw);
      check("err_size_resp", {r1, rl}, 32'h3);
      check("err_size_wait", nw, 32'd1);
      xfer(1'b0, 32'h20, 1'b0, 3'd2, 32'h0, rd, r1, rl, nw);
      check("err_size_mem", rd, 32'h11AABBCC);
      check("err_rd_resp", {r1, rl}, 32'h0);

      // Three wait states, single write and read
      xfer(1'b1, 32'h100, 1'b1, 3'd2, 32'hA5A55A5A, rd, r1, rl, nw);
      check("ws3_wr_wait", nw, 32'd3);
      xfer(1'b1, 32'h100, 1'b0, 3'd2, 32'h0, rd, r1, rl, nw);
      check("ws3_rd_wait", nw, 32'd3);
      check("ws3_rd_data", rd, 32'hA5A55A5A);

      // Four-beat SEQ write burst on the wait-state slave
      dsel = 1'b1; hsel = 1'b1; htrans = 2'b10; haddr = 32'h200; hwrite = 1'b1;
      hsize = 3'd2; hburst = 3'd3;
      @(posedge HCLK); #1;
      dp = 0; cur = 0;
      for (int g = 0; g < 100; g++) begin
         if (cur < 3) begin
            htrans = 2'b11;
            haddr  = 32'h200 + 32'(4 * (cur + 1));
         end else begin
            htrans = 2'b00;
         end
         hwdata = 32'hB0B00000 | 32'(cur);
         @(negedge HCLK);
         dp++;
         r = hready;
         @(posedge HCLK); #1;
         if (r) begin
            if (cur == 3) break;
            cur++;
         end
      end
      hsel = 1'b0; htrans = 2'b00; hburst = 3'd0;
      check("burst_cycles", dp, 32'd16);
      xfer(1'b1, 32'h20C, 1'b0, 3'd2, 32'h0, rd, r1, rl, nw);
      check("burst_beat3", rd, 32'hB0B00003);
      xfer(1'b1, 32'h200, 1'b0, 3'd2, 32'h0, rd, r1, rl, nw);
      check("burst_beat0", rd, 32'hB0B00000);

      // IDLE / BUSY with HSEL, and NONSEQ while the bus is stalled
      dsel = 1'b1; hsel = 1'b1; htrans = 2'b00; haddr = 32'h100; hwrite = 1'b0;
      @(posedge HCLK); #1;
      @(negedge HCLK);
      check("idle_okay", {rdy1, resp1}, 32'h2);
      htrans = 2'b01;
      @(posedge HCLK); #1;
      @(negedge HCLK);
      check("busy_okay", {rdy1, resp1}, 32'h2);
      htrans = 2'b10; stall = 1'b1;
      @(posedge HCLK); #1;
      stall = 1'b0; htrans = 2'b00; hsel = 1'b0;
      @(negedge HCLK);
      check("stall_ignored", {rdy1, resp1}, 32'h2);
      @(posedge HCLK); #1;

      // Reset during the wait phase of a write
      xfer(1'b1, 32'h30, 1'b1, 3'd2, 32'h0, rd, r1, rl, nw);
      dsel = 1'b1; hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
      @(posedge HCLK); #1;
      htrans = 2'b00; hsel = 1'b0; hwdata = 32'hCAFEF00D;
      @(negedge HCLK);
      check("rstw_in_wait", rdy1, 32'h0);
      #2 HRESETn = 1'b0;
      #1;
      check("rstw_rdy", rdy1, 32'h1);
      check("rstw_resp", resp1, 32'h0);
      check("rstw_rdata", rdata1, 32'h0);
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;
      @(posedge HCLK); #1;
      xfer(1'b1, 32'h30, 1'b0, 3'd2, 32'h0, rd, r1, rl, nw);
      check("rstw_mem", rd, 32'h0);
      check("rstw_rd_wait", nw, 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ahb3lite_mem_slave.md
# ahb3lite_mem_slave

Synthesizable AHB3-Lite slave memory that answers the transfers issued by the CPU's AHB master ports. It provides single-port word storage with byte-lane writes and a programmable number of wait states. Illegal transfers get the two-cycle ERROR response. It sits behind the AHB interconnect as a bus responder and serves as the memory target for CPU bus regression benches.

## Interface
- XLEN, 32: data bus width (HWDATA/HRDATA); 32 or 64.
- PHYS_ADDR_SIZE, XLEN: HADDR width.
- MEM_SIZE, 4096: memory size in bytes; power of two, multiple of XLEN/8.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted in every OKAY data phase; 0..15.

- HCLK  input  1  bus clock; all state on rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- HSEL  input  1  slave select from the decoder.
- HADDR  input  PHYS_ADDR_SIZE  byte address (address phase).
- HWDATA  input  XLEN  write data (data phase).
- HRDATA  output  XLEN  read data.
- HWRITE  input  1  1=write, 0=read.
- HSIZE  input  3  transfer size (0=byte, 1=half, 2=word, 3=dword).
- HBURST  input  3  accepted, ignored (each beat is handled as a single transfer).
- HPROT  input  4  accepted, ignored.
- HTRANS  input  2  IDLE/BUSY/NONSEQ/SEQ.
- HMASTLOCK  input  1  accepted, ignored.
- HREADY  input  1  bus-level ready (from the mux).
- HREADYOUT  output  1  this slave's ready.
- HRESP  output  1  0=OKAY, 1=ERROR.

## Operation
**Address phase acceptance**
- A transfer is accepted when HSEL & HREADY & HTRANS∈{NONSEQ,SEQ} at a rising HCLK.
- On acceptance, register the following: word index = HADDR[log2(MEM_SIZE)-1:log2(XLEN/8)], byte-lane mask, HWRITE, and an error flag.

**Lane mask and error**
- Lane mask: the 2^HSIZE lanes starting at HADDR[log2(XLEN/8)-1:0]. Lanes are little-endian; lane 0 = bits 7:0.
- The error flag is set for any of the following:
  - HADDR ≥ MEM_SIZE;
  - HADDR not aligned to 2^HSIZE;
  - 2^HSIZE > XLEN/8.

**State machine**
- IDLE: HREADYOUT=1, HRESP=0.
  - Accepted transfer with error → ERR1.
  - Accepted OKAY transfer with WAIT_STATES>0 → WAIT, counter loaded with WAIT_STATES-1.
  - Accepted OKAY transfer with WAIT_STATES=0 → DATA.
- WAIT: HREADYOUT=0, HRESP=0.
  - Counter decrements each cycle.
  - At 0 → DATA.
- DATA: HREADYOUT=1, HRESP=0. This is the final data-phase cycle.
  - Write: HWDATA lanes in the mask are written into memory on the closing edge.
  - Read: HRDATA is valid in this cycle.
  - Next state follows the IDLE acceptance rules (back-to-back transfers allowed).
- ERR1: HREADYOUT=0, HRESP=1 → ERR2. Error responses never insert wait states.
- ERR2: HREADYOUT=1, HRESP=1.
  - No memory write occurs.
  - Next state follows the IDLE acceptance rules. A master that cancels by driving IDLE is accepted normally.
- IDLE and BUSY transfers get a zero-wait OKAY response and do not change state.

**Read data and forwarding**
- HRDATA holds the last read word until the next read's DATA cycle. It is never driven X.
- Read-after-write forwarding: a read accepted on the same edge that commits a write to the same word returns the merged word (new lanes from the write, old lanes from memory).
- Memory contents are not reset.

## Timing
- Reset (asynchronous, HRESETn=0):
  - State=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, counter=0.
  - A pending write is discarded, not committed.
- OKAY transfer latency: address phase + (WAIT_STATES+1) data-phase cycles.
- ERROR transfer latency: address phase + 2 data-phase cycles.
- The address phase of the next transfer overlaps the final data-phase cycle (DATA or ERR2). No dead cycle is inserted.
- HSEL=1 with HREADY=0 (another slave stalling): the transfer is not accepted and state is unchanged.
- Reads and writes have identical wait-state timing.

## Test plan
- Zero-wait word write then read: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back → HRDATA=0xDEADBEEF in the first read data cycle (forwarding path), HREADYOUT always 1.
- Byte lanes: word 0x20=0x11223344, then byte write 0xAA to 0x22 → read 0x20 returns 0x11AA3344. Halfword write 0xBBCC to 0x20 → read returns 0x11AABBCC.
- WAIT_STATES=3: single read → HREADYOUT low for exactly 3 cycles, data valid in the 4th data-phase cycle. Burst of 4 SEQ writes → 16 data-phase cycles total.
- Errors, each giving HRESP=1 with HREADYOUT 0 then 1, and memory unchanged on readback:
  - write to MEM_SIZE (0x1000);
  - halfword at 0x21;
  - HSIZE=3 on XLEN=32.
- Protocol idle cases:
  - IDLE/BUSY with HSEL=1 → OKAY, zero wait, no state change;
  - NONSEQ with HREADY=0 → ignored.
- Reset mid-operation: assert HRESETn low during WAIT of a write to 0x30 (old 0x0) → outputs immediately HREADYOUT=1, HRESP=0, HRDATA=0. After release, read 0x30 → 0x00000000.
